// File: rtl/spi_debug_ctrl.sv
// Debug command sequencer behind the 32-bit SPI slave: decodes frames, runs
// memory word reads/writes over a req/ready port and drives CPU run/step.
module spi_debug_ctrl #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 11
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NB_DATA-1:0] i_frame_data,
   input  logic               i_frame_valid,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_mem_req,
   output logic               o_mem_we,
   output logic [NB_ADDR-1:0] o_mem_addr,
   output logic [NB_DATA-1:0] o_mem_wdata,
   input  logic               i_mem_ready,
   input  logic [NB_DATA-1:0] i_mem_rdata,
   output logic               o_cpu_run,
   output logic               o_cpu_step,
   output logic               o_busy
);

   typedef enum logic [1:0] {IDLE, WAIT_DATA, MEM_WR, MEM_RD} state_t;

   localparam logic [3:0] OP_SET_ADDR = 4'h1;
   localparam logic [3:0] OP_WRITE    = 4'h2;
   localparam logic [3:0] OP_READ     = 4'h3;
   localparam logic [3:0] OP_STEP     = 4'h4;
   localparam logic [3:0] OP_RUN      = 4'h5;
   localparam logic [3:0] OP_HALT     = 4'h6;
   localparam logic [3:0] OP_STATUS   = 4'h7;

   state_t state, state_next;

   logic [NB_DATA-1:0] frame_q;
   logic               frame_valid_q;
   logic               err_sticky;
   logic [7:0]         err_cnt;
   logic [15:0]        frame_cnt;

   logic [NB_DATA-1:0] tx_next, wdata_next;
   logic [NB_ADDR-1:0] addr_next;
   logic               run_next, step_next, err_event;
   logic [3:0]         opcode;
   logic [NB_DATA-1:0] status_word;

   assign opcode      = frame_q[NB_DATA-1 -: 4];
   assign status_word = {o_cpu_run, err_sticky, 6'b0, err_cnt, frame_cnt};

   // Frames are registered once before decode, which gives the one-cycle
   // frame-to-output latency; frame_cnt counts raw arrivals so STATUS sees itself.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         frame_q       <= '0;
         frame_valid_q <= 1'b0;
         frame_cnt     <= '0;
      end else begin
         frame_q       <= i_frame_data;
         frame_valid_q <= i_frame_valid;
         if (i_frame_valid) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // NOTE: every variable gets its default before the case, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      tx_next    = o_tx_data;
      addr_next  = o_mem_addr;
      wdata_next = o_mem_wdata;
      run_next   = o_cpu_run;
      step_next  = 1'b0;
      err_event  = 1'b0;
      case (state)
         IDLE: begin
            if (frame_valid_q) begin
               case (opcode)
                  OP_SET_ADDR: addr_next  = frame_q[NB_ADDR-1:0];
                  OP_WRITE:    state_next = WAIT_DATA;
                  OP_READ:     state_next = MEM_RD;
                  OP_STEP:     step_next  = 1'b1;
                  OP_RUN:      run_next   = 1'b1;
                  OP_HALT:     run_next   = 1'b0;
                  OP_STATUS:   tx_next    = status_word;
                  default:     err_event  = 1'b1;
               endcase
            end
         end
         WAIT_DATA: begin
            if (frame_valid_q) begin
               wdata_next = frame_q;
               state_next = MEM_WR;
            end
         end
         MEM_WR, MEM_RD: begin
            // A frame landing mid-access is dropped even if the access completes now.
            if (frame_valid_q) err_event = 1'b1;
            if (i_mem_ready) begin
               if (state == MEM_RD) tx_next = i_mem_rdata;
               addr_next  = o_mem_addr + NB_ADDR'(4);
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         o_tx_data   <= '0;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_cpu_run   <= 1'b0;
         o_cpu_step  <= 1'b0;
         o_busy      <= 1'b0;
         err_sticky  <= 1'b0;
         err_cnt     <= '0;
      end else begin
         state       <= state_next;
         o_tx_data   <= tx_next;
         o_mem_req   <= (state_next == MEM_WR) || (state_next == MEM_RD);
         o_mem_we    <= (state_next == MEM_WR);
         o_mem_addr  <= addr_next;
         o_mem_wdata <= wdata_next;
         o_cpu_run   <= run_next;
         o_cpu_step  <= step_next;
         o_busy      <= (state_next != IDLE);
         err_sticky  <= err_sticky | err_event;
         if (err_event && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_spi_debug_ctrl.sv
// Bench for spi_debug_ctrl: command table plus hand sequences, with a memory
// responder that checks each access against a queue of expected accesses.
module tb_spi_debug_ctrl;

   localparam int NB_DATA = 32;
   localparam int NB_ADDR = 11;

   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic [NB_DATA-1:0] i_frame_data = '0;
   logic               i_frame_valid = 1'b0;
   logic [NB_DATA-1:0] o_tx_data;
   logic               o_mem_req, o_mem_we;
   logic [NB_ADDR-1:0] o_mem_addr;
   logic [NB_DATA-1:0] o_mem_wdata;
   logic               i_mem_ready = 1'b0;
   logic [NB_DATA-1:0] i_mem_rdata = '0;
   logic               o_cpu_run, o_cpu_step, o_busy;

   spi_debug_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_frame_data (i_frame_data),
      .i_frame_valid(i_frame_valid),
      .o_tx_data    (o_tx_data),
      .o_mem_req    (o_mem_req),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_ready  (i_mem_ready),
      .i_mem_rdata  (i_mem_rdata),
      .o_cpu_run    (o_cpu_run),
      .o_cpu_step   (o_cpu_step),
      .o_busy       (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0]        frame;
      logic               run;
      logic [31:0]        tx;
      logic [NB_ADDR-1:0] addr;
   } vec_t;

   typedef struct {
      logic               we;
      logic [NB_ADDR-1:0] addr;
      logic [31:0]        wdata;
      logic [31:0]        rdata;
      int                 len;   // 0 = length not checked
   } mem_exp_t;

   vec_t     vecs[6];
   vec_t     cmd_q[$];
   mem_exp_t mem_q[$];

   int ready_delay = 0;
   bit hold_low    = 1'b0;
   int req_cnt     = 0;

   // Memory responder: checks the held access every cycle and completes it
   // after ready_delay cycles unless hold_low is set.
   always @(negedge i_clk) begin
      mem_exp_t cur;
      if (o_mem_req) begin
         check("mem_q_size", mem_q.size() > 0, 1);
         if (mem_q.size() > 0) begin
            cur = mem_q[0];
            check("mem_we_addr", {o_mem_we, o_mem_addr}, {cur.we, cur.addr});
            if (cur.we) check("mem_wdata", o_mem_wdata, cur.wdata);
            if (!hold_low && req_cnt >= ready_delay) begin
               i_mem_ready = 1'b1;
               i_mem_rdata = cur.rdata;
               if (cur.len != 0) check("mem_len", req_cnt + 1, cur.len);
               void'(mem_q.pop_front());
            end else begin
               i_mem_ready = 1'b0;
            end
         end
         req_cnt++;
      end else begin
         i_mem_ready = 1'b0;
         req_cnt     = 0;
      end
   end

   // Caller is at a negedge; returns at the negedge after the decode edge.
   task automatic send_frame(input logic [31:0] f);
      i_frame_data  = f;
      i_frame_valid = 1'b1;
      @(negedge i_clk);
      i_frame_valid = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 100 && (o_busy || o_mem_req); k++) @(negedge i_clk);
      check("idle_busy", {o_busy, o_mem_req}, 2'b00);
   endtask

   task automatic push_mem(input logic we, input logic [NB_ADDR-1:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int len);
      mem_exp_t e;
      e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.len = len;
      mem_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vecs[0] = '{32'h7000_0000, 1'b0, 32'h0000_0001, 11'h000};
      vecs[1] = '{32'h5000_0000, 1'b1, 32'h0000_0001, 11'h000};
      vecs[2] = '{32'h7000_0000, 1'b1, 32'h8000_0003, 11'h000};
      vecs[3] = '{32'h6000_0000, 1'b0, 32'h8000_0003, 11'h000};
      vecs[4] = '{32'h1000_0123, 1'b0, 32'h8000_0003, 11'h123};
      vecs[5] = '{32'h7ABC_DEF0, 1'b0, 32'h0000_0006, 11'h123};

      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      check("reset_state",
            {o_tx_data, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_run, o_cpu_step, o_busy}, '0);

      // Single-frame commands
      for (int i = 0; i < 6; i++) begin
         cmd_q.push_back(vecs[i]);
         send_frame(vecs[i].frame);
         v = cmd_q.pop_front();
         check("tbl_run", o_cpu_run, v.run);
         check("tbl_tx", o_tx_data, v.tx);
         check("tbl_addr", o_mem_addr, v.addr);
      end

      // Write with ready delayed 3 cycles
      send_frame(32'h1000_0010);
      ready_delay = 3;
      push_mem(1'b1, 11'h010, 32'hCAFE_F00D, 32'h0, 4);
      send_frame(32'h2000_0000);
      check("wait_data", {o_busy, o_mem_req}, 2'b10);
      send_frame(32'hCAFE_F00D);
      wait_idle();
      check("wr_addr_inc", o_mem_addr, 11'h014);

      // Reads with address wrap
      ready_delay = 0;
      send_frame(32'h1000_07FC);
      push_mem(1'b0, 11'h7FC, 32'h0, 32'h1234_5678, 1);
      send_frame(32'h3000_0000);
      wait_idle();
      check("rd1_tx", o_tx_data, 32'h1234_5678);
      check("rd1_wrap", o_mem_addr, 11'h000);
      @(negedge i_clk);
      push_mem(1'b0, 11'h000, 32'h0, 32'hA5A5_0F0F, 1);
      send_frame(32'h3000_0000);
      wait_idle();
      check("rd2_tx", o_tx_data, 32'hA5A5_0F0F);
      check("rd2_addr", o_mem_addr, 11'h004);

      // RUN, STEP pulse, HALT
      send_frame(32'h5000_0000);
      check("run_on", o_cpu_run, 1'b1);
      i_frame_data  = 32'h4000_0000;
      i_frame_valid = 1'b1;
      @(negedge i_clk);
      i_frame_valid = 1'b0;
      check("step_early", o_cpu_step, 1'b0);
      @(negedge i_clk);
      check("step_pulse", o_cpu_step, 1'b1);
      @(negedge i_clk);
      check("step_end", o_cpu_step, 1'b0);
      send_frame(32'h6000_0000);
      check("run_off", o_cpu_run, 1'b0);

      // Unknown opcode, then a frame dropped during a stalled read
      send_frame(32'h9000_0000);
      check("bad_op_idle", o_busy, 1'b0);
      hold_low = 1'b1;
      push_mem(1'b0, 11'h004, 32'h0, 32'hDEAD_BEEF, 0);
      send_frame(32'h3000_0000);
      check("rd_stall_busy", o_busy, 1'b1);
      send_frame(32'h5000_0000);
      repeat (3) @(negedge i_clk);
      check("dropped_run", {o_cpu_run, o_mem_req}, 2'b01);
      hold_low = 1'b0;
      wait_idle();
      check("rd3_tx", o_tx_data, 32'hDEAD_BEEF);
      check("rd3_addr", o_mem_addr, 11'h008);
      send_frame(32'h7000_0000);
      check("err_status", o_tx_data, 32'h4002_0013);

      // Reset while a write is pending
      send_frame(32'h5000_0000);
      check("run_before_rst", o_cpu_run, 1'b1);
      hold_low = 1'b1;
      push_mem(1'b1, 11'h008, 32'h1111_2222, 32'h0, 0);
      send_frame(32'h2000_0000);
      send_frame(32'h1111_2222);
      check("wr_pending", o_mem_req, 1'b1);
      i_rst = 1'b1;
      @(negedge i_clk);
      check("mid_rst_state",
            {o_tx_data, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_run, o_cpu_step, o_busy}, '0);
      void'(mem_q.pop_front());
      i_rst    = 1'b0;
      hold_low = 1'b0;
      send_frame(32'h7000_0000);
      check("post_rst_status", o_tx_data, 32'h0000_0001);
      repeat (3) @(negedge i_clk);
      check("no_retry", o_mem_req, 1'b0);
      check("mem_q_empty", mem_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_debug_ctrl.md
# spi_debug_ctrl

Command sequencer behind the 32-bit SPI slave in the MIPS debug path. It decodes each received SPI frame as a debug command, sequences word reads and writes to the processor memory through a request/ready port, and drives the CPU run and step controls. It also loads the word the SPI slave shifts out on the next frame (read data or status).

## Interface
- NB_DATA, 32, SPI frame and memory data width; fixed at 32 (opcode layout depends on it).
- NB_ADDR, 11, memory byte-address width.
- i_clk  in  1  system clock (same clock as the SPI slave).
- i_rst  in  1  synchronous, active-high reset.
- i_frame_data  in  NB_DATA  received word from the SPI slave.
- i_frame_valid  in  1  one-cycle pulse: i_frame_data holds a complete new frame.
- o_tx_data  out  NB_DATA  word for the SPI slave to transmit; the slave loads it at the start of the next frame.
- o_mem_req  out  1  memory access request; held until accepted.
- o_mem_we  out  1  1 = write, 0 = read; valid while o_mem_req is high.
- o_mem_addr  out  NB_ADDR  byte address.
- o_mem_wdata  out  NB_DATA  write data.
- i_mem_ready  in  1  memory accepts or completes the access this cycle.
- i_mem_rdata  in  NB_DATA  read data, valid in the cycle i_mem_ready is high on a read.
- o_cpu_run  out  1  CPU free-run enable.
- o_cpu_step  out  1  one-cycle single-step pulse.
- o_busy  out  1  FSM is not in IDLE.

## Operation
- Opcode is frame[31:28]; operand is frame[NB_ADDR-1:0].
  - 0x1 SET_ADDR: addr <= operand.
  - 0x2 WRITE: the next frame is the data word; then perform a memory write.
  - 0x3 READ: perform a memory read; the read word goes to o_tx_data.
  - 0x4 STEP: pulse o_cpu_step.
  - 0x5 RUN: o_cpu_run <= 1.
  - 0x6 HALT: o_cpu_run <= 0.
  - 0x7 STATUS: o_tx_data <= status word.
  - Any other opcode: error.
- Status word = {o_cpu_run, err_sticky, 6'b0, err_cnt[7:0], frame_cnt[15:0]}.
- FSM states and transitions:
  - IDLE: decode each frame.
    - WRITE → WAIT_DATA.
    - READ → MEM_RD.
    - All other opcodes stay in IDLE.
  - WAIT_DATA: the next frame (any value, no decode) is latched into o_mem_wdata → MEM_WR.
  - MEM_WR / MEM_RD: o_mem_req = 1 until i_mem_ready = 1, then → IDLE.
- Address increment: after each completed access, addr <= addr + 4, wrapping modulo 2^NB_ADDR. SET_ADDR writes the operand unmodified (unaligned addresses allowed).
- frame_cnt: 16-bit, increments on every i_frame_valid, including dropped frames; wraps.
- Errors set err_sticky and increment err_cnt (err_cnt saturates at 255). Errors are:
  - an unknown opcode;
  - a frame arriving in MEM_WR or MEM_RD, which is dropped.
- err_sticky clears only on reset.
- Simultaneous i_frame_valid and i_mem_ready in a MEM state: the access completes normally and the frame is dropped as an error.
- Reset mid-access: o_mem_req drops the next edge and no write is retried. The memory side must tolerate an abandoned request.

## Timing
- Reset values:
  - o_tx_data = 0, o_mem_req = 0, o_mem_we = 0.
  - o_mem_addr = 0, o_mem_wdata = 0.
  - o_cpu_run = 0, o_cpu_step = 0, o_busy = 0.
  - Counters = 0, err_sticky = 0, state = IDLE.
- All outputs are registered. A frame with i_frame_valid at edge N takes effect on outputs after edge N+1 (1-cycle latency).
- o_cpu_step: high for exactly one cycle, at N+1.
- Memory access:
  - o_mem_req rises at N+1 (READ) or at N+1 of the data frame (WRITE).
  - o_mem_addr, o_mem_we and o_mem_wdata are stable while o_mem_req is high.
  - The access completes on the edge where i_mem_ready = 1. o_mem_req is low the following cycle.
  - Minimum access is 1 cycle if i_mem_ready is already high.
- READ: o_tx_data <= i_mem_rdata on the completion edge; addr increments on the same edge.
- o_tx_data changes only on READ completion or STATUS. The host must leave at least 1 idle clk after a READ completes before starting the next frame.

## Test plan
- Reset, then STATUS (0x7000_0000) → o_tx_data = 0x0000_0001 (frame_cnt=1), o_cpu_run = 0.
- SET_ADDR 0x1000_0010, WRITE 0x2000_0000, data 0xCAFE_F00D, i_mem_ready delayed 3 cycles → o_mem_req high 4 cycles with we=1, addr=0x010, wdata=0xCAFE_F00D; addr becomes 0x014.
- SET_ADDR 0x1000_07FC, READ 0x3000_0000 with rdata 0x1234_5678, then READ again → o_tx_data = 0x1234_5678; second access addr = 0x000 (wrap).
- RUN, STEP, HALT → o_cpu_run goes 1 then 0; o_cpu_step high exactly 1 cycle.
- Frame 0x9000_0000, then a frame during MEM_RD with ready held low → err_cnt = 2, err_sticky = 1, dropped frame has no effect, STATUS bit30 = 1.
- i_rst asserted while o_mem_req = 1 → all outputs return to reset values next edge; a subsequent STATUS returns 0x0000_0001.
